// File: rtl/neuron_buffer_sequencer.sv
// Neuron buffer sequencer: ping-pongs two neuron buffers (N1/N2) across the
// layers of a run, issuing read addresses toward the conv unit and write
// addresses for words returned by the pool unit. After each layer the read and
// write buffers swap roles. The last layer's output is left in the read buffer
// for host access.
module neuron_buffer_sequencer #(
    parameter int A = 7,
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [L-1:0] numLayers,
    input  logic [A:0]   readLen,
    input  logic [A:0]   writeLen,
    input  logic         stallIn,
    input  logic         poolValid,
    output logic         readBufferSelect,
    output logic [A-1:0] readBuffAddress,
    output logic [A-1:0] writeBuffAddress,
    output logic         readEn,
    output logic         writeEn,
    output logic [L-1:0] layerIdx,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    typedef enum logic [1:0] {IDLE, RUN, SWAP, DONE} state_t;

    state_t       state_q;
    logic [A:0]   rdCnt_q, wrCnt_q;
    logic [A:0]   readLen_q, writeLen_q;
    logic [L-1:0] numLayers_q, layer_q;
    logic         sel_q, ovf_q;
    logic [A:0]   rdCnt_d, wrCnt_d;
    logic [L:0]   layerNext;
    logic         startOk, layerDone, lastLayer;

    // Counters are one bit wider than the address so a full 2^A-word layer
    // ends at rdCnt==2^A instead of wrapping back to zero.
    assign readEn  = (state_q == RUN) && (rdCnt_q < readLen_q) && !stallIn;
    assign writeEn = (state_q == RUN) && poolValid && (wrCnt_q < writeLen_q);

    assign rdCnt_d   = rdCnt_q + {{A{1'b0}}, 1'b1};
    assign wrCnt_d   = wrCnt_q + {{A{1'b0}}, 1'b1};
    assign layerNext = {1'b0, layer_q} + {{L{1'b0}}, 1'b1};
    assign lastLayer = (layerNext == {1'b0, numLayers_q});
    assign startOk   = start && (numLayers != '0) && (readLen != '0) && (writeLen != '0);
    assign layerDone = (rdCnt_q == readLen_q) && (wrCnt_q == writeLen_q);

    assign readBufferSelect = sel_q;
    assign readBuffAddress  = rdCnt_q[A-1:0];
    assign writeBuffAddress = wrCnt_q[A-1:0];
    assign layerIdx         = layer_q;
    assign busy             = (state_q == RUN) || (state_q == SWAP);
    assign done             = (state_q == DONE);
    assign overflow         = ovf_q;

    // Run sequencing FSM with layer/address counters and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rdCnt_q     <= '0;
            wrCnt_q     <= '0;
            readLen_q   <= '0;
            writeLen_q  <= '0;
            numLayers_q <= '0;
            layer_q     <= '0;
            sel_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // A pool word that could not be written is lost; flag it.
            if (poolValid && !writeEn) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (startOk) begin
                        numLayers_q <= numLayers;
                        readLen_q   <= readLen;
                        writeLen_q  <= writeLen;
                        rdCnt_q     <= '0;
                        wrCnt_q     <= '0;
                        layer_q     <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        rdCnt_q <= '0;
                        wrCnt_q <= '0;
                        layer_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        if (readEn)  rdCnt_q <= rdCnt_d;
                        if (writeEn) wrCnt_q <= wrCnt_d;
                        if (layerDone) state_q <= SWAP;
                    end
                end
                SWAP: begin
                    rdCnt_q <= '0;
                    wrCnt_q <= '0;
                    if (abort) begin
                        layer_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        sel_q <= ~sel_q;
                        if (lastLayer) begin
                            state_q <= DONE;
                        end else begin
                            layer_q <= layerNext[L-1:0];
                            state_q <= RUN;
                        end
                    end
                end
                default: begin
                    if (abort) layer_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_buffer_sequencer.sv
// Directed bench for neuron_buffer_sequencer. Inputs change on the falling
// edge; outputs are logged 1ns later, so cycle c of a run is the c-th cycle
// after the clock edge that accepted start.
module tb_neuron_buffer_sequencer;
    localparam int A = 7;
    localparam int L = 4;

    logic         clk, reset, start, abort, stallIn, poolValid;
    logic [L-1:0] numLayers;
    logic [A:0]   readLen, writeLen;
    logic         readBufferSelect, readEn, writeEn, busy, done, overflow;
    logic [A-1:0] readBuffAddress, writeBuffAddress;
    logic [L-1:0] layerIdx;

    int checks = 0;
    int errors = 0;

    logic         rdEnLog  [0:255];
    logic [A-1:0] rdAddrLog[0:255];
    logic         wrEnLog  [0:255];
    logic [A-1:0] wrAddrLog[0:255];
    logic         doneLog  [0:255];
    logic         busyLog  [0:255];
    logic         selLog   [0:255];
    logic [L-1:0] layerLog [0:255];
    logic         ovfLog   [0:255];

    neuron_buffer_sequencer #(.A(A), .L(L)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .numLayers(numLayers), .readLen(readLen), .writeLen(writeLen),
        .stallIn(stallIn), .poolValid(poolValid),
        .readBufferSelect(readBufferSelect), .readBuffAddress(readBuffAddress),
        .writeBuffAddress(writeBuffAddress), .readEn(readEn), .writeEn(writeEn),
        .layerIdx(layerIdx), .busy(busy), .done(done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; stallIn = 1'b0; poolValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present start for one cycle; accepted at the following rising edge.
    task automatic do_start(input logic [L-1:0] nl, input logic [A:0] rl, input logic [A:0] wl);
        @(negedge clk);
        start = 1'b1; numLayers = nl; readLen = rl; writeLen = wl;
        poolValid = 1'b0; stallIn = 1'b0; abort = 1'b0;
    endtask

    // Drive n cycles from bit masks (bit c = cycle c) and log outputs.
    task automatic run(input int n, input logic [255:0] poolM, input logic [255:0] stallM,
                       input logic [255:0] abortM);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start = 1'b0;
            poolValid = poolM[c];
            stallIn = stallM[c];
            abort = abortM[c];
            #1;
            rdEnLog[c] = readEn;   rdAddrLog[c] = readBuffAddress;
            wrEnLog[c] = writeEn;  wrAddrLog[c] = writeBuffAddress;
            doneLog[c] = done;     busyLog[c] = busy;
            selLog[c] = readBufferSelect; layerLog[c] = layerIdx;
            ovfLog[c] = overflow;
        end
        poolValid = 1'b0; stallIn = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; stallIn = 1'b0; poolValid = 1'b1;
        numLayers = '0; readLen = '0; writeLen = '0;
        #1;
        checks++;
        if ({readBufferSelect, readEn, writeEn, busy, done, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {readBufferSelect, readEn, writeEn, busy, done, overflow});
        end
        checks++;
        if ({readBuffAddress, writeBuffAddress, layerIdx} !== '0) begin
            errors++;
            $display("FAIL reset_counts got %h/%h/%h want 0/0/0",
                     readBuffAddress, writeBuffAddress, layerIdx);
        end
        poolValid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_layer();
        int rd[$]; int wr[$]; int nDone, toggles;
        do_reset();
        do_start(4'd1, 8'd4, 8'd2);
        run(12, 256'h3, 256'h0, 256'h0);
        nDone = 0; toggles = 0;
        for (int c = 0; c < 12; c++) begin
            if (rdEnLog[c]) rd.push_back(int'(rdAddrLog[c]));
            if (wrEnLog[c]) wr.push_back(int'(wrAddrLog[c]));
            if (doneLog[c]) nDone++;
            if (c > 0 && selLog[c] != selLog[c-1]) toggles++;
        end
        checks++;
        if (rd.size() != 4 || rd[0] != 0 || rd[1] != 1 || rd[2] != 2 || rd[3] != 3) begin
            errors++; $display("FAIL single_rd_addrs got %p want 0,1,2,3", rd);
        end
        checks++;
        if (wr.size() != 2 || wr[0] != 0 || wr[1] != 1) begin
            errors++; $display("FAIL single_wr_addrs got %p want 0,1", wr);
        end
        checks++;
        if (nDone != 1 || doneLog[6] !== 1'b1) begin
            errors++; $display("FAIL single_done got count %0d at6=%b want 1 at cycle 6", nDone, doneLog[6]);
        end
        checks++;
        if (selLog[5] !== 1'b0 || selLog[6] !== 1'b1 || toggles != 1) begin
            errors++; $display("FAIL single_sel got c5=%b c6=%b toggles=%0d want 0,1,1",
                               selLog[5], selLog[6], toggles);
        end
        checks++;
        if (busyLog[5] !== 1'b1 || busyLog[6] !== 1'b0 || busyLog[7] !== 1'b0) begin
            errors++; $display("FAIL single_busy got %b%b%b want 100", busyLog[5], busyLog[6], busyLog[7]);
        end
    endtask

    task automatic test_multi_layer();
        int sel[$]; int lay[$]; int nDone;
        do_reset();
        do_start(4'd3, 8'd2, 8'd2);
        run(16, 256'h333, 256'h0, 256'h0);
        nDone = 0;
        for (int c = 0; c < 16; c++) begin
            if (rdEnLog[c] && rdAddrLog[c] == '0) begin
                sel.push_back(int'(selLog[c])); lay.push_back(int'(layerLog[c]));
            end
            if (doneLog[c]) nDone++;
        end
        checks++;
        if (sel.size() != 3 || sel[0] != 0 || sel[1] != 1 || sel[2] != 0) begin
            errors++; $display("FAIL multi_sel got %p want 0,1,0", sel);
        end
        checks++;
        if (lay.size() != 3 || lay[0] != 0 || lay[1] != 1 || lay[2] != 2) begin
            errors++; $display("FAIL multi_layer got %p want 0,1,2", lay);
        end
        checks++;
        if (nDone != 1 || doneLog[12] !== 1'b1 || selLog[12] !== 1'b1) begin
            errors++; $display("FAIL multi_done got count %0d at12=%b sel=%b want 1,1,1",
                               nDone, doneLog[12], selLog[12]);
        end
        checks++;
        if (ovfLog[15] !== 1'b0) begin
            errors++; $display("FAIL multi_ovf got %b want 0", ovfLog[15]);
        end
    endtask

    task automatic test_stall();
        logic [5:0] expEn;
        int expAddr[6] = '{0, 1, 1, 1, 1, 2};
        logic [5:0] gotEn;
        int bad;
        do_reset();
        do_start(4'd1, 8'd3, 8'd1);
        run(10, 256'h1, 256'hE, 256'h0);
        expEn = 6'b110001;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            gotEn[c] = rdEnLog[c];
            if (int'(rdAddrLog[c]) != expAddr[c]) bad++;
        end
        checks++;
        if (gotEn !== expEn) begin
            errors++; $display("FAIL stall_rden got %b want %b", gotEn, expEn);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_addr got %0d bad cycles want 0", bad);
        end
        checks++;
        if (doneLog[8] !== 1'b1) begin
            errors++; $display("FAIL stall_done got %b at cycle 8 want 1", doneLog[8]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        do_start(4'd1, 8'd1, 8'd1);
        run(8, 256'h7, 256'h0, 256'h0);
        checks++;
        if ({wrEnLog[0], wrEnLog[1], wrEnLog[2]} !== 3'b100 || wrAddrLog[0] !== '0) begin
            errors++; $display("FAIL ovf_wren got %b%b%b want 100", wrEnLog[0], wrEnLog[1], wrEnLog[2]);
        end
        checks++;
        if ({ovfLog[0], ovfLog[1], ovfLog[2], ovfLog[7]} !== 4'b0011) begin
            errors++; $display("FAIL ovf_sticky got %b%b%b%b want 0011",
                               ovfLog[0], ovfLog[1], ovfLog[2], ovfLog[7]);
        end
        checks++;
        if (doneLog[3] !== 1'b1) begin
            errors++; $display("FAIL ovf_done got %b at cycle 3 want 1", doneLog[3]);
        end
        do_start(4'd1, 8'd1, 8'd1);
        run(3, 256'h0, 256'h0, 256'h2);
        checks++;
        if (ovfLog[0] !== 1'b0) begin
            errors++; $display("FAIL ovf_clear_on_start got %b want 0", ovfLog[0]);
        end
    endtask

    task automatic test_abort();
        int nDone, selSet, busySet;
        // Abort on the cycle the layer-complete condition is seen.
        do_reset();
        do_start(4'd2, 8'd1, 8'd1);
        run(10, 256'h1, 256'h0, 256'h2);
        nDone = 0; selSet = 0;
        for (int c = 0; c < 10; c++) begin
            if (doneLog[c]) nDone++;
            if (selLog[c]) selSet++;
        end
        checks++;
        if (busyLog[1] !== 1'b1 || busyLog[2] !== 1'b0 || layerLog[2] !== '0) begin
            errors++; $display("FAIL abort_idle got busy %b%b layer %0d want 10,0",
                               busyLog[1], busyLog[2], layerLog[2]);
        end
        checks++;
        if (nDone != 0 || selSet != 0) begin
            errors++; $display("FAIL abort_nodone got done %0d sel %0d want 0,0", nDone, selSet);
        end
        // Abort during the SWAP cycle itself must block the toggle.
        do_reset();
        do_start(4'd2, 8'd1, 8'd1);
        run(6, 256'h1, 256'h0, 256'h4);
        checks++;
        if (selLog[3] !== 1'b0 || busyLog[3] !== 1'b0 || layerLog[3] !== '0) begin
            errors++; $display("FAIL abort_swap got sel %b busy %b layer %0d want 0,0,0",
                               selLog[3], busyLog[3], layerLog[3]);
        end
        // Start with readLen=0 is ignored.
        do_start(4'd1, 8'd0, 8'd1);
        run(5, 256'h0, 256'h0, 256'h0);
        busySet = 0;
        for (int c = 0; c < 5; c++) if (busyLog[c] || rdEnLog[c]) busySet++;
        checks++;
        if (busySet != 0) begin
            errors++; $display("FAIL zero_len_start got %0d busy cycles want 0", busySet);
        end
    endtask

    task automatic test_full_len_and_reset();
        int bad, nRd, nDone;
        do_reset();
        do_start(4'd1, 8'd128, 8'd1);
        run(135, 256'h1, 256'h0, 256'h0);
        bad = 0; nRd = 0;
        for (int c = 0; c < 135; c++) begin
            if (rdEnLog[c]) begin
                nRd++;
                if (c > 127 || int'(rdAddrLog[c]) != c) bad++;
            end
        end
        checks++;
        if (nRd != 128 || bad != 0) begin
            errors++; $display("FAIL full_len_reads got %0d reads %0d bad want 128,0", nRd, bad);
        end
        checks++;
        if (doneLog[130] !== 1'b1 || selLog[130] !== 1'b1) begin
            errors++; $display("FAIL full_len_done got done %b sel %b want 1,1", doneLog[130], selLog[130]);
        end
        // Reset mid-layer: outputs return to reset values without waiting for a clock.
        do_start(4'd2, 8'd20, 8'd4);
        run(6, 256'h3, 256'h0, 256'h0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busyLog[5] !== 1'b1 || busy !== 1'b0 || readEn !== 1'b0 || readBuffAddress !== '0 ||
            writeBuffAddress !== '0 || readBufferSelect !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run got busy %b->%b rden %b ra %0d wa %0d sel %b ovf %b want 1->0,0,0,0,0,0",
                               busyLog[5], busy, readEn, readBuffAddress, writeBuffAddress,
                               readBufferSelect, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        run(20, 256'h0, 256'h0, 256'h0);
        nDone = 0;
        for (int c = 0; c < 20; c++) if (doneLog[c] || busyLog[c]) nDone++;
        checks++;
        if (nDone != 0) begin
            errors++; $display("FAIL reset_discard got %0d busy/done cycles want 0", nDone);
        end
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_multi_layer();
        test_stall();
        test_overflow();
        test_abort();
        test_full_len_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_buffer_sequencer.md
NEURON_BUFFER_SEQUENCER -- requirements
Module: neuron_buffer_sequencer

Interface
REQ-001 SHALL have parameter A, default 7, neuron-buffer address width.
REQ-002 SHALL have parameter L, default 4, layer-count width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a run; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous abort of a run.
REQ-007 SHALL have port numLayers  input  L  layers in the run; sampled on accepted start.
REQ-008 SHALL have port readLen  input  A+1  words read per layer (1..2^A); sampled on accepted start.
REQ-009 SHALL have port writeLen  input  A+1  words written per layer (1..2^A); sampled on accepted start.
REQ-010 SHALL have port stallIn  input  1  conv unit not ready; blocks read issue.
REQ-011 SHALL have port poolValid  input  1  pool unit output word valid this cycle.
REQ-012 SHALL have port readBufferSelect  output  1  0: N1 is read buffer, 1: N2 is read buffer.
REQ-013 SHALL have port readBuffAddress  output  A  read-buffer address (registered counter).
REQ-014 SHALL have port writeBuffAddress  output  A  write-buffer address (registered counter).
REQ-015 SHALL have port readEn  output  1  read issued this cycle (combinational).
REQ-016 SHALL have port writeEn  output  1  pool word written this cycle (combinational).
REQ-017 SHALL have port layerIdx  output  L  current layer, 0-based.
REQ-018 SHALL have port busy  output  1  high in RUN and SWAP.
REQ-019 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-020 SHALL have port overflow  output  1  sticky: poolValid arrived with write count exhausted.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, SWAP, DONE.
REQ-022 IDLE: start=1 with numLayers!=0, readLen!=0, writeLen!=0 SHALL latch the three values, clear counters, layerIdx=0, overflow=0, go RUN; start otherwise ignored.
REQ-023 RUN: readEn SHALL = (readCnt<readLen) && !stallIn; readCnt increments by 1 when readEn.
REQ-024 readBuffAddress SHALL equal readCnt[A-1:0]; writeBuffAddress SHALL equal writeCnt[A-1:0].
REQ-025 RUN: writeEn SHALL = poolValid && (writeCnt<writeLen); writeCnt increments by 1 when writeEn.
REQ-026 poolValid with writeCnt==writeLen, or outside RUN, SHALL drop the word (writeEn=0) and set overflow, held until next accepted start or reset.
REQ-027 readEn and writeEn SHALL be independent; both may assert in the same cycle.
REQ-028 RUN -> SWAP when readCnt==readLen and writeCnt==writeLen (evaluated on registered counts; earliest one cycle after last increment).
REQ-029 SWAP (exactly one cycle, readEn=writeEn=0): readBufferSelect SHALL toggle, counters clear; if layerIdx+1==numLayers -> DONE, else layerIdx increments, -> RUN.
REQ-030 DONE (one cycle): done=1, busy=0, -> IDLE; readBufferSelect retains value so final layer output is in the read buffer for host IO.
REQ-031 readBufferSelect SHALL change only in SWAP or on reset.
REQ-032 abort=1 in RUN/SWAP/DONE SHALL go IDLE next cycle, clear counters and layerIdx, no done pulse, readBufferSelect unchanged; abort beats start and SWAP transition in the same cycle.
REQ-033 readLen=2^A SHALL address 0..2^A-1 without counter wrap (counters A+1 bits).

Reset
REQ-034 reset=1 SHALL immediately force IDLE, readBufferSelect=0, counters=0, layerIdx=0, done=0, overflow=0, busy=0; readEn=writeEn=0 while in reset.
REQ-035 Reset mid-run SHALL discard the run; no done pulse follows.

Verification
REQ-036 Reset, start numLayers=1 readLen=4 writeLen=2, no stall, poolValid two cycles -> read addr 0,1,2,3, write addr 0,1, one SWAP, readBufferSelect 0->1, done one cycle.
REQ-037 numLayers=3 readLen=2 writeLen=2 -> readBufferSelect 0,1,0,1 across layers, layerIdx 0,1,2, single done.
REQ-038 stallIn high cycles 2-4 of RUN with readLen=3 -> readEn low those cycles, readBuffAddress holds, no address skipped or repeated.
REQ-039 writeLen=1, poolValid 3 consecutive cycles -> one writeEn at addr 0, overflow=1 until next start.
REQ-040 abort asserted same cycle as SWAP condition -> IDLE, readBufferSelect unchanged, no done; start with readLen=0 -> ignored, busy stays 0.
REQ-041 readLen=128 (A=7) -> addresses 0..127 each once, then SWAP; reset asserted mid-layer -> outputs at reset values same cycle.
